// File: rtl/reg_file_sb.sv
// Register file with per-register pending-write scoreboard for RAW hazard detection.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int PEND_W   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rstd,
    input  logic [AW-1:0]   rd_addr_a,
    output logic [XLEN-1:0] rd_data_a,
    output logic            busy_a,
    input  logic [AW-1:0]   rd_addr_b,
    output logic [XLEN-1:0] rd_data_b,
    output logic            busy_b,
    output logic            hazard,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    output logic            iss_full,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            wb_err
);

    localparam logic [PEND_W-1:0] PMAX = '1;

    logic [NREG-1:0][XLEN-1:0]   regs_q, regs_d;
    logic [NREG-1:0][PEND_W-1:0] pend_q, pend_d;
    logic                        wb_err_q, wb_err_d;

    always_comb begin : next_state
        logic inc, dec;
        regs_d   = regs_q;
        pend_d   = pend_q;
        wb_err_d = wb_err_q;
        inc      = 1'b0;
        dec      = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if (!(ZERO_REG && r == 0)) begin
                inc = iss_en && (iss_addr == AW'(r)) && (pend_q[r] != PMAX);
                dec = wr_en && (wr_addr == AW'(r)) && (pend_q[r] != '0);
                if (inc && !dec)
                    pend_d[r] = pend_q[r] + 1'b1;
                else if (dec && !inc)
                    pend_d[r] = pend_q[r] - 1'b1;
                if (wr_en && (wr_addr == AW'(r))) begin
                    regs_d[r] = wr_data;
                    // An issue landing in the same cycle covers the write, so no error.
                    if ((pend_q[r] == '0) && !inc)
                        wb_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            regs_q   <= '0;
            pend_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            pend_q   <= pend_d;
            wb_err_q <= wb_err_d;
        end
    end

    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        rd_data_b = regs_q[rd_addr_b];
        busy_a    = pend_q[rd_addr_a] != '0;
        busy_b    = pend_q[rd_addr_b] != '0;
`ifdef REGFILE_BYPASS_EN
        // A matching writeback retires one pending write this cycle.
        if (wr_en && (wr_addr == rd_addr_a) && !(ZERO_REG && rd_addr_a == '0)) begin
            rd_data_a = wr_data;
            busy_a    = pend_q[rd_addr_a] > PEND_W'(1);
        end
        if (wr_en && (wr_addr == rd_addr_b) && !(ZERO_REG && rd_addr_b == '0)) begin
            rd_data_b = wr_data;
            busy_b    = pend_q[rd_addr_b] > PEND_W'(1);
        end
`endif
        if (ZERO_REG && rd_addr_a == '0) rd_data_a = '0;
        if (ZERO_REG && rd_addr_b == '0) rd_data_b = '0;
    end

    assign hazard   = busy_a | busy_b;
    assign iss_full = pend_q[iss_addr] == PMAX;
    assign wb_err   = wb_err_q;

endmodule
